// File: rtl/hazard_select_ctrl_pkg.sv
// Shared definitions for the hazard/select controller: mux select codes,
// the hardwired-zero register number and the per-stage shadow entry.
package hazard_select_ctrl_pkg;

  // 2-bit select codes driven onto the pipeline's 3:1 muxes
  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_FWD  = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

  // Register numbers are held at this width inside the shadow entries;
  // narrower architectural addresses are zero-extended into it.
  localparam int SHADOW_AW = 8;

  localparam logic [SHADOW_AW-1:0] REG_ZERO = '0;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic                 v;   // stage holds a real instruction
    logic [SHADOW_AW-1:0] rd;  // destination register
    logic                 rw;  // writes a register
    logic                 ld;  // is a load (result only available after MEM)
  } shadow_t;

endpackage

// File: rtl/hazard_select_ctrl_match.sv
// Compares one ID source register against one in-flight shadow entry.
// Register zero is hardwired and never produces a dependency.
module hazard_match
  import hazard_select_ctrl_pkg::*;
(
  input  logic                 i_uses,
  input  logic [SHADOW_AW-1:0] i_src,
  input  logic                 i_v,
  input  logic                 i_rw,
  input  logic [SHADOW_AW-1:0] i_rd,
  output logic                 o_match
);

  // A producer matters only if it is valid, writes, targets our source and is not $0
  always_comb begin
    o_match = i_uses & i_v & i_rw & (i_rd == i_src) & (i_src != REG_ZERO);
  end

endmodule

// File: rtl/hazard_select_ctrl.sv
// Select-side hazard controller: tracks EX/MEM destinations, decides stall,
// forwarding and bubble/flush, and drives the pipeline mux select codes.
module hazard_select_ctrl
  import hazard_select_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,   // must not exceed SHADOW_AW
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [1:0]        ifid_sel,
  output logic [1:0]        idex_sel,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  shadow_t              r_ex;
  shadow_t              r_mem;
  logic [1:0]           r_fwd_a;
  logic [1:0]           r_fwd_b;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic [CNT_W-1:0]     r_flush_cnt;

  logic [SHADOW_AW-1:0] w_rs;
  logic [SHADOW_AW-1:0] w_rt;
  logic [SHADOW_AW-1:0] w_rd;
  logic                 w_m1_rs;
  logic                 w_m1_rt;
  logic                 w_m2_rs;
  logic                 w_m2_rt;
  logic                 w_stall;
  logic                 w_stall_eff;
  logic                 w_advance;

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  assign w_rs = SHADOW_AW'(id_rs);
  assign w_rt = SHADOW_AW'(id_rt);
  assign w_rd = SHADOW_AW'(id_rd);

  hazard_match u_m1_rs (.i_uses(id_uses_rs), .i_src(w_rs), .i_v(r_ex.v),
                        .i_rw(r_ex.rw), .i_rd(r_ex.rd), .o_match(w_m1_rs));
  hazard_match u_m1_rt (.i_uses(id_uses_rt), .i_src(w_rt), .i_v(r_ex.v),
                        .i_rw(r_ex.rw), .i_rd(r_ex.rd), .o_match(w_m1_rt));
  hazard_match u_m2_rs (.i_uses(id_uses_rs), .i_src(w_rs), .i_v(r_mem.v),
                        .i_rw(r_mem.rw), .i_rd(r_mem.rd), .o_match(w_m2_rs));
  hazard_match u_m2_rt (.i_uses(id_uses_rt), .i_src(w_rt), .i_v(r_mem.v),
                        .i_rw(r_mem.rw), .i_rd(r_mem.rd), .o_match(w_m2_rt));

  // Stall decision: MEM producers and EX loads cannot be forwarded; a taken
  // branch overrides the stall because the stalled instruction is flushed anyway
  always_comb begin
    w_stall     = id_valid & (w_m2_rs | w_m2_rt | ((w_m1_rs | w_m1_rt) & r_ex.ld));
    w_stall_eff = w_stall & ~ex_branch_taken;
    w_advance   = ~w_stall & ~ex_branch_taken;
  end

  // Front-end enables and IF/ID, ID/EX mux selects
  always_comb begin
    pc_write   = ~w_stall_eff;
    ifid_write = ~w_stall_eff;
    ifid_sel   = ex_branch_taken ? SEL_ZERO : SEL_PASS;
    idex_sel   = (w_stall | ex_branch_taken) ? SEL_ZERO : SEL_PASS;
  end

  // Shadow pipeline: MEM takes EX; EX takes the ID instruction or a bubble
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else begin
      r_mem <= r_ex;
      if (w_advance) begin
        r_ex <= '{v: id_valid, rd: w_rd, rw: id_reg_write, ld: id_mem_read};
      end else begin
        r_ex <= '0;
      end
    end
  end

  // Forward selects are registered so they line up with the instruction in EX
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_fwd_a <= SEL_PASS;
      r_fwd_b <= SEL_PASS;
    end else begin
      r_fwd_a <= (w_advance & id_valid & w_m1_rs & ~r_ex.ld) ? SEL_FWD : SEL_PASS;
      r_fwd_b <= (w_advance & id_valid & w_m1_rt & ~r_ex.ld) ? SEL_FWD : SEL_PASS;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_eff)     r_stall_cnt <= sat_inc(r_stall_cnt);
      if (ex_branch_taken) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign ex_fwd_a_sel = r_fwd_a;
  assign ex_fwd_b_sel = r_fwd_b;
  assign stall_count  = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_select_ctrl.sv
// Testbench for hazard_select_ctrl: directed vector table, saturation run,
// asynchronous reset check and randomized run against a reference model.
module tb_hazard_select_ctrl;

  localparam int TB_CNT_W = 8;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt;
    bit       urs, urt;
    bit [4:0] rd;
    bit       rw, ld, br;
  } in_t;

  typedef struct {
    in_t      i;
    bit       pcw;
    bit [1:0] ifs, ids, fa, fb;
    int       sc, fc;
  } vec_t;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw, ld;
  } ent_t;

  logic                Clk = 1'b0;
  logic                Rst_n = 1'b0;
  logic                id_valid = 1'b0;
  logic [4:0]          id_rs = '0, id_rt = '0, id_rd = '0;
  logic                id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic                id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic                ex_branch_taken = 1'b0;
  logic                pc_write, ifid_write;
  logic [1:0]          ifid_sel, idex_sel, ex_fwd_a_sel, ex_fwd_b_sel;
  logic [TB_CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  // Reference model: the two instructions in flight ahead of ID
  ent_t m_pipe [1:2];
  bit   m_fa, m_fb;
  int   m_sc, m_fc;

  vec_t tbl [24];

  hazard_select_ctrl #(.REG_AW(5), .CNT_W(TB_CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_sel(ifid_sel), .idex_sel(idex_sel), .ex_fwd_a_sel(ex_fwd_a_sel),
    .ex_fwd_b_sel(ex_fwd_b_sel), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mki(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                              input bit urs, input bit urt, input bit [4:0] rd,
                              input bit rw, input bit ld, input bit br);
    in_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
    x.rd = rd; x.rw = rw; x.ld = ld; x.br = br;
    return x;
  endfunction

  function automatic vec_t mkv(input in_t x, input bit pcw, input bit [1:0] ifs,
                               input bit [1:0] ids, input bit [1:0] fa,
                               input bit [1:0] fb, input int sc, input int fc);
    vec_t r;
    r.i = x; r.pcw = pcw; r.ifs = ifs; r.ids = ids; r.fa = fa; r.fb = fb;
    r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic model_clear();
    m_pipe[1] = '{default: 0};
    m_pipe[2] = '{default: 0};
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endtask

  // A producer one slot ahead can be bypassed unless it is a load; anything
  // two slots ahead (or a load one ahead) forces ID to wait.
  task automatic model_eval(input in_t x, output bit stall, output bit fa, output bit fb);
    bit wait_req = 0;
    fa = 0; fb = 0;
    for (int s = 0; s < 2; s++) begin
      bit [4:0] src = (s == 0) ? x.rs : x.rt;
      bit       use_it = (s == 0) ? x.urs : x.urt;
      if (use_it && src != 0) begin
        for (int d = 1; d <= 2; d++) begin
          if (m_pipe[d].v && m_pipe[d].rw && m_pipe[d].rd == src) begin
            if (d == 2 || m_pipe[d].ld) wait_req = 1;
            else if (s == 0) fa = 1;
            else fb = 1;
          end
        end
      end
    end
    stall = x.v && wait_req;
  endtask

  task automatic apply(input in_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs;
    id_uses_rt = x.urt; id_rd = x.rd; id_reg_write = x.rw;
    id_mem_read = x.ld; ex_branch_taken = x.br;
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, clock,
  // then check registered outputs; the model always advances.
  task automatic cyc(input in_t x, input bit use_model, input vec_t row, input bit use_row);
    bit st, fa, fb, adv;
    apply(x);
    model_eval(x, st, fa, fb);
    adv = !st && !x.br;
    @(negedge Clk);
    if (use_model) begin
      chk("pc_write", pc_write, !(st && !x.br));
      chk("ifid_write", ifid_write, !(st && !x.br));
      chk("ifid_sel", ifid_sel, x.br ? 2 : 0);
      chk("idex_sel", idex_sel, (st || x.br) ? 2 : 0);
    end
    if (use_row) begin
      chk("tbl_pc_write", pc_write, row.pcw);
      chk("tbl_ifid_write", ifid_write, row.pcw);
      chk("tbl_ifid_sel", ifid_sel, row.ifs);
      chk("tbl_idex_sel", idex_sel, row.ids);
    end
    @(posedge Clk);
    #1;
    m_pipe[2] = m_pipe[1];
    if (adv) m_pipe[1] = '{v: x.v, rd: x.rd, rw: x.rw, ld: x.ld};
    else     m_pipe[1] = '{default: 0};
    m_fa = adv && x.v && fa;
    m_fb = adv && x.v && fb;
    if (st && !x.br && m_sc < CMAX) m_sc++;
    if (x.br && m_fc < CMAX) m_fc++;
    if (use_model) begin
      chk("fwd_a", ex_fwd_a_sel, m_fa ? 1 : 0);
      chk("fwd_b", ex_fwd_b_sel, m_fb ? 1 : 0);
      chk("stall_count", stall_count, m_sc);
      chk("flush_count", flush_count, m_fc);
    end
    if (use_row) begin
      chk("tbl_fwd_a", ex_fwd_a_sel, row.fa);
      chk("tbl_fwd_b", ex_fwd_b_sel, row.fb);
      chk("tbl_stall_count", stall_count, row.sc);
      chk("tbl_flush_count", flush_count, row.fc);
    end
  endtask

  initial begin
    in_t  nop, x, lwself;
    vec_t dummy;
    bit   st, fa, fb;
    nop    = mki(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lwself = mki(1, 1, 0, 1, 0, 1, 1, 1, 0);
    dummy  = mkv(nop, 1, 0, 0, 0, 0, 0, 0);

    // ALU back-to-back, distance-2, load-use, branch over stall, $0
    tbl[0]  = mkv(mki(1, 1, 2, 1, 1, 3, 1, 0, 0), 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(mki(1, 3, 2, 1, 1, 6, 1, 0, 0), 1, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mkv(nop, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(nop, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mkv(mki(1, 1, 2, 1, 1, 5, 1, 0, 0), 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(nop, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(mki(1, 7, 5, 1, 1, 8, 1, 0, 0), 0, 0, 2, 0, 0, 1, 0);
    tbl[7]  = mkv(mki(1, 7, 5, 1, 1, 8, 1, 0, 0), 1, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mkv(nop, 1, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mkv(nop, 1, 0, 0, 0, 0, 1, 0);
    tbl[10] = mkv(mki(1, 1, 0, 1, 0, 4, 1, 1, 0), 1, 0, 0, 0, 0, 1, 0);
    tbl[11] = mkv(mki(1, 4, 4, 1, 1, 9, 1, 0, 0), 0, 0, 2, 0, 0, 2, 0);
    tbl[12] = mkv(mki(1, 4, 4, 1, 1, 9, 1, 0, 0), 0, 0, 2, 0, 0, 3, 0);
    tbl[13] = mkv(mki(1, 4, 4, 1, 1, 9, 1, 0, 0), 1, 0, 0, 0, 0, 3, 0);
    tbl[14] = mkv(nop, 1, 0, 0, 0, 0, 3, 0);
    tbl[15] = mkv(nop, 1, 0, 0, 0, 0, 3, 0);
    tbl[16] = mkv(mki(1, 1, 0, 1, 0, 4, 1, 1, 0), 1, 0, 0, 0, 0, 3, 0);
    tbl[17] = mkv(mki(1, 4, 4, 1, 1, 9, 1, 0, 1), 1, 2, 2, 0, 0, 3, 1);
    tbl[18] = mkv(nop, 1, 0, 0, 0, 0, 3, 1);
    tbl[19] = mkv(nop, 1, 0, 0, 0, 0, 3, 1);
    tbl[20] = mkv(mki(1, 1, 2, 1, 1, 0, 1, 0, 0), 1, 0, 0, 0, 0, 3, 1);
    tbl[21] = mkv(mki(1, 0, 0, 1, 1, 10, 1, 0, 0), 1, 0, 0, 0, 0, 3, 1);
    tbl[22] = mkv(mki(1, 0, 0, 1, 1, 10, 1, 0, 0), 1, 0, 0, 0, 0, 3, 1);
    tbl[23] = mkv(nop, 1, 0, 0, 0, 0, 3, 1);

    // Power-on reset
    model_clear();
    #3;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    chk("rst_ifid_sel", ifid_sel, 0);
    chk("rst_idex_sel", idex_sel, 0);
    chk("rst_fwd_a", ex_fwd_a_sel, 0);
    chk("rst_fwd_b", ex_fwd_b_sel, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);
    #20;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int k = 0; k < 24; k++) cyc(tbl[k].i, 1'b0, tbl[k], 1'b1);

    // Back-to-back self-dependent loads drive the stall counter to saturation
    for (int k = 0; k < 420; k++) cyc(lwself, 1'b1, dummy, 1'b0);
    chk("sat_stall_count", stall_count, CMAX);
    for (int k = 0; k < 3; k++) cyc(lwself, 1'b1, dummy, 1'b0);
    chk("sat_stall_hold", stall_count, CMAX);
    for (int k = 0; k < 2; k++) cyc(nop, 1'b1, dummy, 1'b0);

    // Asynchronous reset mid-stream with a forward select set and a load in EX
    cyc(mki(1, 1, 2, 1, 1, 3, 1, 0, 0), 1'b1, dummy, 1'b0);
    cyc(mki(1, 3, 0, 1, 0, 4, 1, 1, 0), 1'b1, dummy, 1'b0);
    chk("pre_rst_fwd_a", ex_fwd_a_sel, 1);
    x = mki(1, 4, 0, 1, 0, 9, 1, 0, 0);
    apply(x);
    model_eval(x, st, fa, fb);
    #1;
    chk("pre_rst_pc_write", pc_write, st ? 0 : 1);
    Rst_n = 1'b0;
    #1;
    chk("arst_pc_write", pc_write, 1);
    chk("arst_ifid_write", ifid_write, 1);
    chk("arst_idex_sel", idex_sel, 0);
    chk("arst_fwd_a", ex_fwd_a_sel, 0);
    chk("arst_fwd_b", ex_fwd_b_sel, 0);
    chk("arst_stall_count", stall_count, 0);
    chk("arst_flush_count", flush_count, 0);
    model_clear();
    apply(nop);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Randomized traffic on a small register set to keep hazards frequent
    for (int k = 0; k < 3000; k++) begin
      x.v   = ($urandom_range(0, 9) < 8);
      x.rs  = 5'($urandom_range(0, 3));
      x.rt  = 5'($urandom_range(0, 3));
      x.urs = 1'($urandom);
      x.urt = 1'($urandom);
      x.rd  = 5'($urandom_range(0, 3));
      x.rw  = ($urandom_range(0, 3) != 0);
      x.ld  = ($urandom_range(0, 2) == 0);
      x.br  = ($urandom_range(0, 9) == 0);
      cyc(x, 1'b1, dummy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_select_ctrl.md
Name: hazard_select_ctrl

Overview:
- Select-side controller for the pipeline's 3:1 operand and control muxes.
- Tracks in-flight destination registers for the EX and MEM stages in shadow registers.
- Each cycle it decides:
  - whether the ID instruction must stall,
  - whether its operands are forwarded in EX,
  - whether a bubble is injected.
- It drives the 2-bit mux select codes: 00 = normal/register-file path, 01 = forwarded EX/MEM result, 10 = zero (bubble/flush).

Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, width of the saturating stall/flush counters

Ports:
- Clk in 1 pipeline clock, rising edge
- Rst_n in 1 asynchronous reset, active low
- id_valid in 1 ID stage holds a real instruction
- id_rs in REG_AW ID source register A
- id_rt in REG_AW ID source register B
- id_uses_rs in 1 instruction reads rs
- id_uses_rt in 1 instruction reads rt
- id_rd in REG_AW ID destination register (already resolved rd/rt)
- id_reg_write in 1 ID instruction writes a register
- id_mem_read in 1 ID instruction is a load
- ex_branch_taken in 1 branch/jump resolved taken in EX this cycle
- pc_write out 1 PC update enable
- ifid_write out 1 IF/ID register load enable
- ifid_sel out 2 IF/ID mux select: 00 pass, 10 zero (flush)
- idex_sel out 2 ID/EX control-bus mux select: 00 pass, 10 zero (bubble)
- ex_fwd_a_sel out 2 EX operand-A mux select, registered: 00 regfile, 01 EX/MEM forward
- ex_fwd_b_sel out 2 EX operand-B mux select, registered: same encoding as A
- stall_count out CNT_W saturating count of stall cycles
- flush_count out CNT_W saturating count of taken-branch flushes

Behaviour:
- Shadow state:
  - ex_{v,rd,rw,ld} and mem_{v,rd,rw,ld}.
  - Each rising edge: mem <= ex; ex <= ID fields when ID advances, else a bubble (v=0).
- Reset (Rst_n low, async):
  - All shadow valids = 0.
  - ex_fwd_a_sel = ex_fwd_b_sel = 00.
  - Both counters = 0.
  - Combinational outputs then evaluate to pc_write=1, ifid_write=1, ifid_sel=00, idex_sel=00.
- Hazard match, per ID source s ∈ {rs, rt}:
  - match1(s) = uses_s & ex_v & ex_rw & ex_rd==s & s!=0
  - match2(s) = uses_s & mem_v & mem_rw & mem_rd==s & s!=0
  - Register 0 never creates a hazard.
- Stall condition (combinational, same cycle), stall = id_valid & any(match2 | (match1 & ex_ld)):
  - A distance-2 producer cannot be forwarded, so ID waits until the producer reaches WB; the register file is write-first.
  - A load at distance 1 cannot be forwarded; it stalls, becomes distance 2, and stalls again. Load-use therefore costs exactly 2 cycles.
- When stalling:
  - pc_write=0, ifid_write=0, idex_sel=10.
  - ex shadow loads a bubble.
  - ex_fwd_*_sel loads 00.
- Forwarding, when not stalling:
  - ex_fwd_a_sel <= match1(rs) & !ex_ld ? 01 : 00. Operand B is computed identically from rt.
  - Selects are registered so they align with the instruction entering EX.
- Taken branch (ex_branch_taken=1):
  - Flushes IF/ID and ID: ifid_sel=10, idex_sel=10, pc_write=1, ifid_write=1.
  - ex shadow loads a bubble; fwd selects load 00.
  - It overrides stall in the same cycle.
- id_valid=0: no stall and no forwarding; the ID fields are still shifted in with v=0.
- Counters:
  - stall_count increments on each stall cycle that is not overridden.
  - flush_count increments on each taken-branch cycle.
  - Both saturate at all-ones; there is no wrap.
- Code 11 is never driven.

Decomposition:
- Shared package holds:
  - select encodings SEL_PASS=2'b00, SEL_FWD=2'b01, SEL_ZERO=2'b10
  - REG_ZERO = 0
  - struct {v, rd, rw, ld} for a stage shadow entry
- One natural sub-module: hazard_match, a combinational comparator of one source against one shadow entry, returning match.
  - Instantiate it 4×: rs/rt × ex/mem.

Test Plan:
- Reset: hold Rst_n=0 mid-stream with ex_v=1 → selects 00, counters 0, pc_write=1, idex_sel=00 immediately, asynchronously.
- ALU back-to-back: add $3 then sub using $3 as rs → no stall; ex_fwd_a_sel=01 in the consumer's EX cycle; ex_fwd_b_sel=00.
- Distance-2: add $5, an unrelated nop, then or reading rt=$5 → exactly 1 stall cycle (pc_write=0, idex_sel=10); then ex_fwd_b_sel=00.
- Load-use: lw $4 then add reading $4 → 2 stall cycles; stall_count=2; the consumer enters EX with selects 00.
- Branch over stall: ex_branch_taken=1 while a load-use stall is pending → ifid_sel=10, idex_sel=10, pc_write=1; flush_count=1; stall_count unchanged.
- $0 and saturation: producer writing $0 followed by a reader of $0 → no stall, selects 00. Preload stall_count=16'hFFFF and stall once more → stays 16'hFFFF.
